// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver, bundled so the
// receiver and whoever drives/consumes it share one connection.
interface uart_rx_if;
   logic       tick;
   logic       rx;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic       busy;

   // Driver side: supplies the oversampling tick and the serial line,
   // observes the received byte and status.
   modport master (
      output tick,
      output rx,
      input  dout,
      input  rx_done_tick,
      input  frame_err,
      input  busy
   );

   // Receiver side.
   modport slave (
      input  tick,
      input  rx,
      output dout,
      output rx_done_tick,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, DBIT data bits LSB first,
// no parity, SB_TICK-tick stop period. Emits a byte, a one-clock done
// strobe and a framing-error flag for each completed frame.
module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input logic      clk,
   input logic      rst_n,
   uart_rx_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Tick counts at which each phase ends.
   localparam logic [4:0] S_MID      = 5'd7;
   localparam logic [4:0] S_BIT_LAST = 5'd15;
   localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

   logic            rx_meta_q;
   logic            rx_s_q;

   logic [1:0]      state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [2:0]      n_q, n_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic [7:0]      dout_q, dout_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            busy_q, busy_d;

   // Two-flop synchroniser on the asynchronous line; idles high so reset
   // never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Frame sequencer: find the start edge, confirm it at mid-bit, sample
   // each data bit at its centre, then check the stop level at the end of
   // the stop period and publish the byte.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end

         ST_START: begin
            if (bus.tick) begin
               if (s_q == S_MID) begin
                  if (!rx_s_q) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end

         ST_DATA: begin
            if (bus.tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  shift_d = {rx_s_q, shift_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end

         ST_STOP: begin
            if (bus.tick) begin
               if (s_q == S_STOP_END) begin
                  state_d = ST_IDLE;
                  dout_d  = 8'(shift_q);
                  ferr_d  = ~rx_s_q;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and output registers; a reset drops any partial frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.dout         = dout_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = ferr_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (8 data bits / 1 stop bit and
// 7 data bits / 1.5 stop bits) share clock, reset and a 1-in-4 tick.
// A frame-level model predicts each byte, error flag and done deadline.
module tb_uart_rx;

   localparam int CLK_PER_BIT = 64;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      longint     lo;
      longint     hi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned total = 0;
   int unsigned bad = 0;
   longint      cyc = 0;
   bit          rstTaken = 1'b0;
   bit          chkOn = 1'b0;
   int          tickPh = 0;
   int          doneCnt [2];
   logic [7:0]  lastDout [2];
   logic        lastFerr [2];
   exp_t        expQ [2][$];

   uart_rx_if if8 ();
   uart_rx_if if7 ();

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   uart_rx #(.DBIT(7), .SB_TICK(24)) dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));

   // Free-running system clock.
   always #5 clk = ~clk;

   // Cycle count and "reset was taken on this edge" flag.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rstTaken <= !rst_n;
   end

   // Oversampling tick: one clock in every four.
   initial begin
      if8.tick = 1'b0;
      if7.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tickPh   = (tickPh + 1) % 4;
         if8.tick = (tickPh == 0);
         if7.tick = (tickPh == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setRx(input int k, input logic v);
      if (k == 0) if8.rx = v;
      else        if7.rx = v;
   endtask

   function automatic int dbitOf(input int k);
      return (k == 0) ? 8 : 7;
   endfunction

   function automatic int sbOf(input int k);
      return (k == 0) ? 16 : 24;
   endfunction

   // Queue the model's prediction for a frame whose start bit begins now.
   // The done pulse lands after 8 + 16*DBIT + SB_TICK ticks of 4 clocks,
   // give or take synchroniser lag and tick phase.
   task automatic expectFrame(input int k, input logic [7:0] d, input logic fe, input longint t0);
      exp_t e;
      longint span;
      span = longint'(8 + 16 * dbitOf(k) + sbOf(k)) * 4;
      e.d  = d & (8'hFF >> (8 - dbitOf(k)));
      e.fe = fe;
      e.lo = t0 + span - 8;
      e.hi = t0 + span + 12;
      expQ[k].push_back(e);
   endtask

   // Drive one whole frame. A low stop bit is held only long enough to be
   // sampled, and followed by idle so the re-entered start check rejects.
   task automatic sendFrame(input int k, input logic [7:0] d, input logic stopOk);
      int stopLen;
      expectFrame(k, d, !stopOk, cyc);
      setRx(k, 1'b0);
      step(CLK_PER_BIT);
      for (int j = 0; j < dbitOf(k); j++) begin
         setRx(k, d[j]);
         step(CLK_PER_BIT);
      end
      setRx(k, stopOk);
      if (stopOk) stopLen = (k == 0) ? 64 : 96;
      else        stopLen = (k == 0) ? 48 : 80;
      step(stopLen);
      setRx(k, 1'b1);
      if (!stopOk) step(100);
   endtask

   // Start a frame, then reset the receivers half-way through data bit 4.
   task automatic abortFrame(input int k, input logic [7:0] d);
      setRx(k, 1'b0);
      step(CLK_PER_BIT);
      for (int j = 0; j < 4; j++) begin
         setRx(k, d[j]);
         step(CLK_PER_BIT);
      end
      setRx(k, d[4]);
      step(CLK_PER_BIT / 2);
      rst_n = 1'b0;
      setRx(k, 1'b1);
      step(3);
      rst_n = 1'b1;
      step(100);
   endtask

   task automatic waitDone(input int k, input int target, input int maxClk);
      int n = 0;
      while (doneCnt[k] < target && n < maxClk) begin
         step(1);
         n++;
      end
      check("doneCount", 32'(doneCnt[k]), 32'(target));
   endtask

   // Compare process: every cycle, outputs must be reset values after a
   // taken reset, a predicted frame on a done pulse, and otherwise hold.
   always @(negedge clk) begin
      if (chkOn) begin
         for (int k = 0; k < 2; k++) begin
            logic [7:0] od;
            logic       odone, ofe, obusy;
            exp_t       e;
            od    = (k == 0) ? if8.dout         : if7.dout;
            odone = (k == 0) ? if8.rx_done_tick : if7.rx_done_tick;
            ofe   = (k == 0) ? if8.frame_err    : if7.frame_err;
            obusy = (k == 0) ? if8.busy         : if7.busy;
            if (rstTaken) begin
               check("rstDout", 32'(od), 32'h0);
               check("rstDone", 32'(odone), 32'h0);
               check("rstFerr", 32'(ofe), 32'h0);
               check("rstBusy", 32'(obusy), 32'h0);
               lastDout[k] = 8'h00;
               lastFerr[k] = 1'b0;
            end else begin
               while (expQ[k].size() > 0 && cyc > expQ[k][0].hi) begin
                  check("missedDone", 32'(doneCnt[k]), 32'(doneCnt[k] + 1));
                  void'(expQ[k].pop_front());
               end
               if (odone) begin
                  doneCnt[k]++;
                  check("doneExpected", 32'(expQ[k].size() != 0), 32'h1);
                  if (expQ[k].size() != 0) begin
                     e = expQ[k].pop_front();
                     check("doneWindow", 32'(cyc >= e.lo && cyc <= e.hi), 32'h1);
                     check("dout", 32'(od), 32'(e.d));
                     check("frameErr", 32'(ofe), 32'(e.fe));
                     lastDout[k] = e.d;
                     lastFerr[k] = e.fe;
                  end
               end else begin
                  check("doutHold", 32'(od), 32'(lastDout[k]));
                  check("ferrHold", 32'(ofe), 32'(lastFerr[k]));
               end
            end
         end
      end
   end

   // Directed scenarios followed by randomized frames.
   initial begin
      int base;
      longint t0;
      logic [7:0] d;
      logic ok;
      int k;

      rst_n  = 1'b0;
      if8.rx = 1'b1;
      if7.rx = 1'b1;
      doneCnt[0] = 0;
      doneCnt[1] = 0;
      step(3);
      chkOn = 1'b1;
      check("resetDout8", 32'(if8.dout), 32'h0);
      check("resetBusy8", 32'(if8.busy), 32'h0);
      check("resetDout7", 32'(if7.dout), 32'h0);
      rst_n = 1'b1;
      step(100);
      check("idleBusy8", 32'(if8.busy), 32'h0);
      check("idleBusy7", 32'(if7.busy), 32'h0);

      $display("[TB] nominal 0xA5");
      sendFrame(0, 8'hA5, 1'b1);
      check("litA5", 32'(if8.dout), 32'hA5);
      check("litA5ferr", 32'(if8.frame_err), 32'h0);
      check("litA5count", 32'(doneCnt[0]), 32'h1);

      $display("[TB] framing error then clean");
      sendFrame(0, 8'h3C, 1'b0);
      check("lit3C", 32'(if8.dout), 32'h3C);
      check("lit3Cferr", 32'(if8.frame_err), 32'h1);
      sendFrame(0, 8'h81, 1'b1);
      check("lit81", 32'(if8.dout), 32'h81);
      check("lit81ferr", 32'(if8.frame_err), 32'h0);

      $display("[TB] glitch reject");
      setRx(0, 1'b0);
      step(10);
      check("glitchBusyHigh", 32'(if8.busy), 32'h1);
      step(2);
      setRx(0, 1'b1);
      step(38);
      check("glitchBusyLow", 32'(if8.busy), 32'h0);
      check("glitchKeepsDout", 32'(if8.dout), 32'h81);

      $display("[TB] back-to-back");
      base = doneCnt[0];
      sendFrame(0, 8'h00, 1'b1);
      sendFrame(0, 8'hFF, 1'b1);
      sendFrame(0, 8'h55, 1'b1);
      check("b2bCount", 32'(doneCnt[0] - base), 32'h3);
      check("lit55", 32'(if8.dout), 32'h55);

      $display("[TB] reset mid-frame");
      abortFrame(0, 8'hC3);
      check("abortDout", 32'(if8.dout), 32'h0);
      check("abortBusy", 32'(if8.busy), 32'h0);
      sendFrame(0, 8'h12, 1'b1);
      check("lit12", 32'(if8.dout), 32'h12);
      abortFrame(1, 8'h55);
      sendFrame(1, 8'hFF, 1'b1);
      check("lit7F", 32'(if7.dout), 32'h7F);

      $display("[TB] break");
      base = doneCnt[0];
      t0   = cyc;
      expectFrame(0, 8'h00, 1'b1, t0);
      expectFrame(0, 8'h00, 1'b1, t0 + 608);
      setRx(0, 1'b0);
      waitDone(0, base + 2, 1400);
      setRx(0, 1'b1);
      step(200);
      check("breakFerr", 32'(if8.frame_err), 32'h1);
      check("breakBusy", 32'(if8.busy), 32'h0);

      $display("[TB] random frames");
      for (int i = 0; i < 12; i++) begin
         k  = int'($urandom_range(0, 1));
         d  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         sendFrame(k, d, ok);
         step(int'($urandom_range(0, 80)));
      end

      step(200);
      check("pending8", 32'(expQ[0].size()), 32'h0);
      check("pending7", 32'(expQ[1].size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
